proj_to_affine: RTL and testbench
=================================

PROJ_TO_AFFINE -- requirements
Module: proj_to_affine

Interface
REQ-001 Parameter: N, default 233, field width in bits (GF(2^233), f(x)=x^233+x^74+1).
REQ-002 Parameter: TIMEOUT, default 4095, maximum cycles spent waiting for an inverter response.
REQ-003 CLK  input  1  single clock, all logic on rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 IN_VALID  input  1  one-cycle strobe; X_IN and Z_IN are valid.
REQ-006 X_IN  input  N  projective X coordinate.
REQ-007 Z_IN  input  N  projective Z coordinate.
REQ-008 BUSY  output  1  high from acceptance until the OUT_VALID or ERROR cycle.
REQ-009 INV_IN_VALID  output  1  one-cycle request strobe to the field inverter.
REQ-010 INV_DIN  output  N  operand for the inverter (latched Z).
REQ-011 INV_OUT_VALID  input  1  inverter result strobe.
REQ-012 INV_DOUT  input  N  inverter result Z^-1.
REQ-013 DOUT  output  N  affine x = X * Z^-1 mod f.
REQ-014 OUT_VALID  output  1  one-cycle strobe; DOUT valid.
REQ-015 ERROR  output  1  one-cycle strobe on Z=0, timeout or check failure.

Function
REQ-016 States: IDLE, REQ, WAIT, MUL, CHK (macro only), DONE.
REQ-017 IDLE: on IN_VALID, latch X_IN and Z_IN; if Z_IN==0 pulse ERROR next cycle, DOUT=0, stay IDLE; else go to REQ.
REQ-018 REQ: drive INV_IN_VALID=1 for exactly one cycle, go to WAIT.
REQ-019 INV_DIN SHALL equal latched Z and stay stable from REQ through DONE.
REQ-020 WAIT: on INV_OUT_VALID latch INV_DOUT, clear timeout counter, go to MUL; INV_OUT_VALID outside WAIT is ignored.
REQ-021 WAIT: counter increments each cycle; when it reaches TIMEOUT without response, pulse ERROR and return to IDLE.
REQ-022 MUL: bit-serial MSB-first multiply, exactly N cycles; acc <= (acc*x mod f) xor (b[i] ? a : 0), a = latched X, b = Z^-1, acc cleared on entry.
REQ-023 Reduction: the shifted-out bit 232 is folded into bits 74 and 0.
REQ-024 DONE: DOUT <= acc, OUT_VALID=1 for one cycle, return to IDLE; BUSY falls in the same cycle.
REQ-025 Latency without the macro: IN_VALID to OUT_VALID = 2 + L_inv + N + 1 cycles, where L_inv is the cycle count from INV_IN_VALID to INV_OUT_VALID.
REQ-026 IN_VALID while BUSY SHALL be ignored, with no effect on state or latched operands.
REQ-027 DOUT SHALL hold its last value until the next OUT_VALID or Z=0 ERROR.
REQ-028 OUT_VALID and ERROR SHALL never be high in the same cycle.

Reset
REQ-029 RST_N low SHALL immediately force IDLE and clear, at any state including mid-MUL: BUSY, INV_IN_VALID, OUT_VALID, ERROR, DOUT, INV_DIN, all latched operands, acc and counters.
REQ-030 After reset release the first IN_VALID SHALL be accepted normally; no stale inverter response is used.

Configuration
REQ-031 Macro INV_RESULT_CHECK_EN defined: after MUL, state CHK reruns the serial multiplier on Z * Z^-1 (N cycles); result !=1 pulses ERROR with no OUT_VALID; result ==1 goes to DONE.
REQ-032 With the macro defined, latency grows by N cycles.
REQ-033 Macro undefined: no CHK state or logic, MUL goes directly to DONE.

Verification
REQ-034 X=1, Z=1, inverter model returns 1 -> OUT_VALID once, DOUT=1, latency per REQ-025.
REQ-035 X=2, Z=2, model returns x^232+x^73 -> DOUT=1.
REQ-036 X=5, Z=0 -> ERROR pulse 1 cycle after IN_VALID, no INV_IN_VALID, DOUT=0.
REQ-037 Inverter never responds -> ERROR after TIMEOUT=4095 WAIT cycles, BUSY low, next request accepted.
REQ-038 RST_N asserted on cycle 100 of MUL -> all outputs 0 at once; then X=3, Z=1 -> DOUT=3.
REQ-039 INV_RESULT_CHECK_EN defined, Z=2, model returns 1 (wrong) -> ERROR, no OUT_VALID; second IN_VALID while BUSY ignored.

Source files
------------

// File: rtl/proj_to_affine_if.sv
// Handshake bundle for proj_to_affine: operand strobe, inverter request/response
// and result/error strobes. The design side uses the slave modport.
interface proj_to_affine_if #(
    parameter int N = 233
);
    logic         in_valid;
    logic [N-1:0] x_in;
    logic [N-1:0] z_in;
    logic         busy;
    logic         inv_in_valid;
    logic [N-1:0] inv_din;
    logic         inv_out_valid;
    logic [N-1:0] inv_dout;
    logic [N-1:0] dout;
    logic         out_valid;
    logic         error;

    modport slave (
        input  in_valid, x_in, z_in, inv_out_valid, inv_dout,
        output busy, inv_in_valid, inv_din, dout, out_valid, error
    );

    modport master (
        output in_valid, x_in, z_in, inv_out_valid, inv_dout,
        input  busy, inv_in_valid, inv_din, dout, out_valid, error
    );
endinterface

// File: rtl/proj_to_affine.sv
// Projective-to-affine conversion over GF(2^233): x = X * Z^-1 using an external inverter
// and a bit-serial MSB-first multiplier. Define INV_RESULT_CHECK_EN to verify Z * Z^-1 == 1.
//
// state  | meaning
// IDLE   | waiting for in_valid; Z=0 pulses error here
// REQ    | one-cycle inverter request
// WAIT   | waiting for inverter response, bounded by TIMEOUT
// MUL    | N-cycle serial multiply X * Z^-1
// CHK    | N-cycle serial multiply Z * Z^-1, must equal 1 (macro build only)
// DONE   | publish result
module proj_to_affine #(
    parameter int N       = 233,
    parameter int TIMEOUT = 4095
) (
    input  logic               clk,
    input  logic               rst_n,
    proj_to_affine_if.slave    bus
);

    localparam int CW_T = $clog2(TIMEOUT + 1);
    localparam int CW_N = $clog2(N);
    localparam int CW   = (CW_T > CW_N) ? CW_T : CW_N;

    // f(x) = x^233 + x^74 + 1: the overflow bit folds back into bits 74 and 0
    localparam logic [N-1:0] POLY = (N'(1) << 74) | N'(1);
    localparam logic [N-1:0] ONE  = N'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_MUL,
`ifdef INV_RESULT_CHECK_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  z_q, z_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          out_valid_q, out_valid_d;
    logic          error_q, error_d;
`ifdef INV_RESULT_CHECK_EN
    logic [N-1:0]  zinv_q, zinv_d;
    logic [N-1:0]  res_q, res_d;
`endif

    logic [N-1:0]  mul_a;
    logic [N-1:0]  acc_step;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        z_d         = z_q;
        acc_d       = acc_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        out_valid_d = 1'b0;
        error_d     = 1'b0;
`ifdef INV_RESULT_CHECK_EN
        zinv_d      = zinv_q;
        res_d       = res_q;
        mul_a       = (state_q == S_CHK) ? z_q : x_q;
`else
        mul_a       = x_q;
`endif
        // one MSB-first step: acc*x mod f, then add a if the current multiplier bit is set
        acc_step = {acc_q[N-2:0], 1'b0} ^ (acc_q[N-1] ? POLY : '0) ^ (b_q[N-1] ? mul_a : '0);

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    x_d = bus.x_in;
                    z_d = bus.z_in;
                    if (bus.z_in == '0) begin
                        error_d = 1'b1;
                        dout_d  = '0;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.inv_out_valid) begin
                    b_d     = bus.inv_dout;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MUL;
`ifdef INV_RESULT_CHECK_EN
                    zinv_d  = bus.inv_dout;
`endif
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_MUL: begin
                acc_d = acc_step;
                b_d   = b_q << 1;
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d = '0;
`ifdef INV_RESULT_CHECK_EN
                    res_d   = acc_step;
                    acc_d   = '0;
                    b_d     = zinv_q;
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef INV_RESULT_CHECK_EN
            S_CHK: begin
                acc_d = acc_step;
                b_d   = b_q << 1;
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d = '0;
                    if (acc_step == ONE) begin
                        state_d = S_DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            S_DONE: begin
`ifdef INV_RESULT_CHECK_EN
                dout_d = res_q;
`else
                dout_d = acc_q;
`endif
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            z_q         <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
`ifdef INV_RESULT_CHECK_EN
            zinv_q      <= '0;
            res_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            z_q         <= z_d;
            acc_q       <= acc_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            error_q     <= error_d;
`ifdef INV_RESULT_CHECK_EN
            zinv_q      <= zinv_d;
            res_q       <= res_d;
`endif
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.inv_in_valid = (state_q == S_REQ);
    assign bus.inv_din      = z_q;
    assign bus.dout         = dout_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.error        = error_q;

endmodule

// File: tb/tb_proj_to_affine.sv
// Randomized bench for proj_to_affine against a polynomial-arithmetic GF(2^233) model.
module tb_proj_to_affine;

    localparam int N       = 233;
    localparam int TIMEOUT = 4095;
    localparam logic [N-1:0] ONE = N'(1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    proj_to_affine_if #(.N(N)) bus ();

    proj_to_affine #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [N-1:0] last_dout = '0;

    task automatic check_eq(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // full polynomial product, then reduce from the top using x^233 = x^74 + 1
    function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-2:0] p;
        p = '0;
        for (int i = 0; i < N; i++)
            if (b[i]) p ^= ({{(N-1){1'b0}}, a} << i);
        for (int k = 2*N-2; k >= N; k--) begin
            if (p[k]) begin
                p[k]        = 1'b0;
                p[k-N+74]   = ~p[k-N+74];
                p[k-N]      = ~p[k-N];
            end
        end
        return p[N-1:0];
    endfunction

    // Fermat inverse: z^(2^233 - 2) = prod_{i=1..232} z^(2^i)
    function automatic logic [N-1:0] gf_inv(input logic [N-1:0] z);
        logic [N-1:0] r, s;
        r = ONE;
        s = z;
        for (int i = 1; i < N; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [N-1:0] rand_elem();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = (r << 32) | N'($urandom());
        return r;
    endfunction

    function automatic logic [N-1:0] rand_nz();
        logic [N-1:0] r;
        r = rand_elem();
        if (r == '0) r = ONE;
        return r;
    endfunction

    task automatic run_txn(input string name, input logic [N-1:0] x, input logic [N-1:0] z,
                           input logic [N-1:0] resp, input int lat, input bit respond,
                           input int poke_t, input int rst_t);
        bit           exp_err;
        int           exp_t;
        logic [N-1:0] exp_dout;
        int n_req = 0, n_out = 0, n_err = 0, n_both = 0;
        int req_t = -1, end_t = -1, budget;
        logic busy1 = 1'b0, busy_end = 1'b1;
        logic [N-1:0] dout_ev = '0;

        exp_err  = 1'b0;
        exp_dout = last_dout;
        if (z == '0) begin
            exp_err = 1'b1; exp_t = 1; exp_dout = '0;
        end else if (!respond) begin
            exp_err = 1'b1; exp_t = TIMEOUT + 2;
        end else begin
            exp_t    = 3 + lat + N;
            exp_dout = gf_mul(x, resp);
`ifdef INV_RESULT_CHECK_EN
            if (gf_mul(z, resp) != ONE) begin
                exp_err = 1'b1; exp_t = 2 + lat + 2*N; exp_dout = last_dout;
            end else begin
                exp_t += N;
            end
`endif
        end
        budget = exp_t + 20;

        @(negedge clk);
        bus.x_in = x; bus.z_in = z; bus.in_valid = 1'b1;
        for (int t = 1; t <= budget; t++) begin
            @(negedge clk);
            if (t == rst_t) begin
                rst_n = 1'b0;
                bus.in_valid = 1'b0; bus.inv_out_valid = 1'b0;
                #1;
                check_eq({name, "/rst_busy"},  N'(bus.busy), '0);
                check_eq({name, "/rst_req"},   N'(bus.inv_in_valid), '0);
                check_eq({name, "/rst_out"},   N'(bus.out_valid), '0);
                check_eq({name, "/rst_err"},   N'(bus.error), '0);
                check_eq({name, "/rst_dout"},  bus.dout, '0);
                check_eq({name, "/rst_din"},   bus.inv_din, '0);
                last_dout = '0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                bus.inv_out_valid = 1'b1; bus.inv_dout = rand_elem();
                @(negedge clk);
                bus.inv_out_valid = 1'b0;
                check_eq({name, "/stale_busy"}, N'(bus.busy), '0);
                return;
            end
            if (bus.inv_in_valid) begin n_req++; req_t = t; end
            if (t == 1) busy1 = bus.busy;
            if (bus.out_valid && bus.error) n_both++;
            if ((bus.out_valid || bus.error) && end_t < 0) begin
                end_t = t; busy_end = bus.busy; dout_ev = bus.dout;
            end
            if (bus.out_valid) n_out++;
            if (bus.error) n_err++;

            bus.in_valid = (t == poke_t);
            bus.x_in = rand_elem();
            bus.z_in = rand_nz();
            bus.inv_out_valid = respond && (req_t > 0) && (t == req_t + lat);
            bus.inv_dout = bus.inv_out_valid ? resp : rand_elem();
            if (end_t > 0 && t >= end_t + 3) break;
        end
        bus.in_valid = 1'b0; bus.inv_out_valid = 1'b0;

        check_eq({name, "/n_req"}, N'(n_req), N'(z != '0));
        check_eq({name, "/n_out"}, N'(n_out), N'(!exp_err));
        check_eq({name, "/n_err"}, N'(n_err), N'(exp_err));
        check_eq({name, "/latency"}, N'(end_t), N'(exp_t));
        check_eq({name, "/both"}, N'(n_both), '0);
        check_eq({name, "/busy_start"}, N'(busy1), N'(z != '0));
        check_eq({name, "/busy_end"}, N'(busy_end), '0);
        check_eq({name, "/dout_ev"}, dout_ev, exp_dout);
        last_dout = exp_dout;
        check_eq({name, "/dout_hold"}, bus.dout, last_dout);
    endtask

    initial begin
        logic [N-1:0] x, z, r2;
        bus.in_valid = 1'b0; bus.x_in = '0; bus.z_in = '0;
        bus.inv_out_valid = 1'b0; bus.inv_dout = '0;
        repeat (3) @(negedge clk);
        check_eq("reset/busy", N'(bus.busy), '0);
        check_eq("reset/out", N'(bus.out_valid), '0);
        check_eq("reset/err", N'(bus.error), '0);
        check_eq("reset/req", N'(bus.inv_in_valid), '0);
        check_eq("reset/dout", bus.dout, '0);
        check_eq("reset/din", bus.inv_din, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn("one", ONE, ONE, ONE, 3, 1'b1, 0, 0);
        r2 = '0; r2[232] = 1'b1; r2[73] = 1'b1;
        run_txn("inv_x", N'(2), N'(2), r2, 1, 1'b1, 0, 0);

        for (int i = 0; i < 4; i++) begin
            x = rand_elem(); z = rand_nz();
            run_txn("rand", x, z, gf_inv(z), int'($urandom_range(1, 8)), 1'b1, (i == 1) ? 6 : 0, 0);
        end

        run_txn("z_zero", N'(5), '0, '0, 1, 1'b1, 0, 0);

        x = rand_elem(); z = rand_nz();
        run_txn("timeout", x, z, '0, 1, 1'b0, 0, 0);
        x = rand_elem(); z = rand_nz();
        run_txn("after_to", x, z, gf_inv(z), 2, 1'b1, 0, 0);

        x = rand_elem(); z = rand_nz();
        run_txn("mid_mul_rst", x, z, gf_inv(z), 2, 1'b1, 0, 2 + 2 + 99);
        run_txn("post_rst", N'(3), ONE, ONE, 1, 1'b1, 0, 0);

        x = rand_elem();
        run_txn("bad_inv", x, N'(2), ONE, 2, 1'b1, 10, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
